// File: rtl/gpio_ctrl.sv
// GPIO controller: direction, output data with set/clear, synchronised inputs, edge IRQ status.
// Writes take effect next cycle, reads return one cycle after sel&rd, no backpressure.
module gpio_ctrl #(
    parameter int            N           = 8,
    parameter int            SYNC_STAGES = 2,
    parameter logic [N-1:0]  OUT_RST     = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sel,
    input  logic [2:0]   addr,
    input  logic         rd,
    input  logic [3:0]   wr,
    input  logic [31:0]  wdata,
    output logic [31:0]  rdata,
    input  logic [N-1:0] gpio_i,
    output logic [N-1:0] gpio_o,
    output logic [N-1:0] gpio_oe,
    output logic         irq
);

    localparam logic [2:0] A_OUT  = 3'd0;
    localparam logic [2:0] A_DIR  = 3'd1;
    localparam logic [2:0] A_IN   = 3'd2;
    localparam logic [2:0] A_RISE = 3'd3;
    localparam logic [2:0] A_FALL = 3'd4;
    localparam logic [2:0] A_STAT = 3'd5;
    localparam logic [2:0] A_SET  = 3'd6;
    localparam logic [2:0] A_CLR  = 3'd7;

    logic [N-1:0] data_out, dir, rise_en, fall_en, status;
    logic [N-1:0] sync_q [SYNC_STAGES];
    logic [N-1:0] s, s_d;
    logic [31:0]  lane32;
    logic [N-1:0] lane_m, wbits, set_mask, clr_mask;
    logic [N-1:0] data_out_nxt, rd_val;
    logic [31:0]  rd_word;
    logic         unused_bus;

    // Byte-lane mask already qualified by sel, so an unselected cycle writes nothing.
    assign lane32     = {{8{wr[3]}}, {8{wr[2]}}, {8{wr[1]}}, {8{wr[0]}}} & {32{sel}};
    assign lane_m     = lane32[N-1:0];
    assign wbits      = wdata[N-1:0] & lane_m;
    assign unused_bus = ^{wdata, lane32};

    assign s        = sync_q[SYNC_STAGES-1];
    assign set_mask = (s & ~s_d & rise_en) | (~s & s_d & fall_en);
    assign clr_mask = (addr == A_STAT) ? wbits : '0;

    always_comb begin
        data_out_nxt = data_out;
        case (addr)
            A_OUT:   data_out_nxt = (data_out & ~lane_m) | wbits;
            A_SET:   data_out_nxt = data_out | wbits;
            A_CLR:   data_out_nxt = data_out & ~wbits;
            default: data_out_nxt = data_out;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= OUT_RST;
            dir      <= '0;
            rise_en  <= '0;
            fall_en  <= '0;
            status   <= '0;
            irq      <= 1'b0;
        end else begin
            data_out <= data_out_nxt;
            if (addr == A_DIR)  dir     <= (dir & ~lane_m) | wbits;
            if (addr == A_RISE) rise_en <= (rise_en & ~lane_m) | wbits;
            if (addr == A_FALL) fall_en <= (fall_en & ~lane_m) | wbits;
            // A newly detected edge outranks a same-cycle clear.
            status   <= (status & ~clr_mask) | set_mask;
            irq      <= |status;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            s_d <= '0;
        end else begin
            sync_q[0] <= gpio_i;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            s_d <= s;
        end
    end

    always_comb begin
        rd_val = '0;
        case (addr)
            A_OUT:   rd_val = data_out;
            A_DIR:   rd_val = dir;
            A_IN:    rd_val = s;
            A_RISE:  rd_val = rise_en;
            A_FALL:  rd_val = fall_en;
            A_STAT:  rd_val = status;
            default: rd_val = '0;
        endcase
        rd_word = '0;
        rd_word[N-1:0] = rd_val;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            rdata <= '0;
        else if (sel && rd) rdata <= rd_word;
    end

    assign gpio_o  = data_out;
    assign gpio_oe = dir;

endmodule
